// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types and constants for the AES round controller.
//   aes_state_t  controller FSM state encoding
//   NR_128/192/256  legal AES round counts
//   legal_nr()   returns rounds if legal, otherwise the supplied default
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEYX = 3'd1,
        ST_R0   = 3'd2,
        ST_RND  = 3'd3,
        ST_OUT  = 3'd4
    } aes_state_t;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] legal_nr(input logic [3:0] rounds,
                                            input logic [3:0] dflt = NR_256);
        case (rounds)
            NR_128, NR_192, NR_256: legal_nr = rounds;
            default:                legal_nr = dflt;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: request/response and datapath-control bundle of the
// AES round controller.
//   master: requester side (drives in_valid/in_new_key/rounds_in/out_ready)
//   slave : controller side (drives handshake responses and datapath strobes)
//
// Handshake semantics: a request transfers on a cycle where in_valid and
// in_ready are both high; a result transfers on a cycle where out_valid and
// out_ready are both high. A valid, once raised by the controller, is held
// with stable data until the matching ready is seen. in_ready is only ever
// high while the controller is idle.
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_new_key;
    logic [3:0] rounds_in;
    logic       dp_load;
    logic       kx_en;
    logic [3:0] kx_idx;
    logic       rd_en;
    logic [3:0] rd_idx;
    logic       rd_first;
    logic       rd_last;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    modport master (
        output in_valid, in_new_key, rounds_in, out_ready,
        input  in_ready, dp_load, kx_en, kx_idx, rd_en, rd_idx,
               rd_first, rd_last, out_valid, busy
    );

    modport slave (
        input  in_valid, in_new_key, rounds_in, out_ready,
        output in_ready, dp_load, kx_en, kx_idx, rd_en, rd_idx,
               rd_first, rd_last, out_valid, busy
    );
endinterface

// File: rtl/aes_round_cnt.sv
// aes_round_cnt: loadable 4-bit up-counter shared by key expansion and the
// round sequence, with a terminal compare against the active round count.
//   clk_in, rst_in  clock, asynchronous active-low reset
//   load, load_val  synchronous load (wins over inc)
//   inc             count up by one
//   nr              terminal value
//   cnt, at_nr      current count, cnt == nr
module aes_round_cnt (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    input  logic [3:0] nr,
    output logic [3:0] cnt,
    output logic       at_nr
);
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)   cnt <= 4'd0;
        else if (load) cnt <= load_val;
        else if (inc)  cnt <= cnt + 4'd1;
    end

    assign at_nr = (cnt == nr);
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencing controller for the iterative AES datapath.
// Accepts a block request, runs a key-expansion pass when the key or round
// count changed, then the initial AddRoundKey and nr rounds, one per clock,
// and holds the result valid until consumed.
//   clk_in, rst_in  clock, asynchronous active-low reset
//   bus             aes_round_ctrl_if.slave (handshakes + datapath strobes)
//   state_dbg       current FSM state
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NK__KEY_LENGTH = 8,
    parameter int NR__ROUNDS     = 14
) (
    input  logic             clk_in,
    input  logic             rst_in,
    aes_round_ctrl_if.slave  bus,
    output aes_state_t       state_dbg
);
    // Default round count: Nk+6 when that is a legal AES round count,
    // otherwise NR__ROUNDS. With Nk=8 this is 14.
    localparam logic [3:0] NR_DFLT =
        legal_nr(4'(NK__KEY_LENGTH + 6), 4'(NR__ROUNDS));

    aes_state_t state, state_nx;
    logic [3:0] nr_q, kx_nr_q;
    logic       key_ok_q;
    logic [3:0] cnt;
    logic       at_nr;
    logic       accept, need_kx, cnt_load, cnt_inc;
    logic [3:0] nr_sel, cnt_load_val;

    assign accept  = (state == ST_IDLE) && bus.in_valid;
    assign nr_sel  = legal_nr(bus.rounds_in, NR_DFLT);
    // Expanded keys are reusable only for the same key and the same nr.
    assign need_kx = bus.in_new_key || !key_ok_q || (nr_sel != kx_nr_q);

    // Counter restarts at 0 entering KEYX and at 1 entering RND (from R0).
    assign cnt_load     = (accept && need_kx) || (state == ST_R0);
    assign cnt_load_val = (state == ST_R0) ? 4'd1 : 4'd0;
    assign cnt_inc      = (state == ST_KEYX) || (state == ST_RND);

    aes_round_cnt u_cnt (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .nr       (nr_q),
        .cnt      (cnt),
        .at_nr    (at_nr)
    );

    // State register plus the per-request/key-cache registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= ST_IDLE;
            nr_q     <= NR_DFLT;
            kx_nr_q  <= NR_DFLT;
            key_ok_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) nr_q <= nr_sel;
            if (state == ST_KEYX && at_nr) begin
                key_ok_q <= 1'b1;
                kx_nr_q  <= nr_q;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = need_kx ? ST_KEYX : ST_R0;
            ST_KEYX: if (at_nr) state_nx = ST_R0;
            ST_R0:   state_nx = ST_RND;
            ST_RND:  if (at_nr) state_nx = ST_OUT;
            ST_OUT:  if (bus.out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output decode: only in_ready/dp_load look at inputs.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.dp_load   = 1'b0;
        bus.kx_en     = 1'b0;
        bus.kx_idx    = 4'd0;
        bus.rd_en     = 1'b0;
        bus.rd_idx    = 4'd0;
        bus.rd_first  = 1'b0;
        bus.rd_last   = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                bus.dp_load  = accept;
            end
            ST_KEYX: begin
                bus.kx_en  = 1'b1;
                bus.kx_idx = cnt;
            end
            ST_R0: begin
                bus.rd_en    = 1'b1;
                bus.rd_first = 1'b1;
            end
            ST_RND: begin
                bus.rd_en   = 1'b1;
                bus.rd_idx  = cnt;
                bus.rd_last = at_nr;
            end
            ST_OUT:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench for aes_round_ctrl. Drivers push the
// expected per-cycle output trace and accept-to-out_valid latency into
// queues; a monitor pops and compares on every cycle the DUT is busy or
// loading.
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    localparam int W = 16;

    logic       clk_in = 1'b0;
    logic       rst_in;
    aes_state_t state_dbg;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(.NK__KEY_LENGTH(8), .NR__ROUNDS(14)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         mdl_key_ok;
    logic [3:0]   mdl_kx_nr;

    // {busy, in_ready, dp_load, kx_en, kx_idx, rd_en, rd_idx, rd_first, rd_last, out_valid}
    function automatic logic [W-1:0] mk_sig(input logic bz, input logic rdy,
        input logic dl, input logic kx, input logic [3:0] kidx, input logic rd,
        input logic [3:0] ridx, input logic rf, input logic rl, input logic ov);
        return {bz, rdy, dl, kx, kidx, rd, ridx, rf, rl, ov};
    endfunction

    function automatic logic [W-1:0] act_sig();
        return mk_sig(bus.busy, bus.in_ready, bus.dp_load, bus.kx_en, bus.kx_idx,
                      bus.rd_en, bus.rd_idx, bus.rd_first, bus.rd_last, bus.out_valid);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- monitor ----------------
    initial begin
        int   lat;
        bit   lat_run;
        logic prev_ov;
        lat = 0; lat_run = 0; prev_ov = 1'b0;
        forever begin
            @(negedge clk_in);
            if (rst_in !== 1'b1) begin
                lat_run = 0;
                prev_ov = 1'b0;
            end else begin
                if (bus.busy || bus.dp_load) begin
                    if (exp_q.size() == 0) fail_now("unexpected_active_cycle");
                    else check("trace", 32'(act_sig()), 32'(exp_q.pop_front()));
                end
                if (bus.dp_load) begin
                    lat = 0;
                    lat_run = 1;
                end else if (lat_run) begin
                    lat++;
                end
                if (bus.out_valid && !prev_ov && lat_run) begin
                    if (lat_q.size() == 0) fail_now("unexpected_out_valid");
                    else check("latency", 32'(lat), 32'(lat_q.pop_front()));
                    lat_run = 0;
                end
                prev_ov = bus.out_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // stop_at != 0: trace ends after RND index stop_at (request is reset there).
    task automatic push_trace(input bit need_kx, input int nr, input int hold, input int stop_at);
        exp_q.push_back(mk_sig(0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0));
        if (need_kx)
            for (int i = 0; i <= nr; i++)
                exp_q.push_back(mk_sig(1, 0, 0, 1, 4'(i), 0, 4'd0, 0, 0, 0));
        exp_q.push_back(mk_sig(1, 0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0));
        for (int i = 1; i <= nr; i++) begin
            if (stop_at != 0 && i > stop_at) break;
            exp_q.push_back(mk_sig(1, 0, 0, 0, 4'd0, 1, 4'(i), 0, (i == nr), 0));
        end
        if (stop_at == 0)
            for (int k = 0; k <= hold; k++)
                exp_q.push_back(mk_sig(1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1));
    endtask

    // Issues one request (inputs driven #1 after posedge) and returns in IDLE.
    task automatic issue(input bit new_key, input logic [3:0] rounds, input int hold,
                         input int stop_at, output bit need_kx, output int nr);
        nr = (rounds == 4'd10 || rounds == 4'd12 || rounds == 4'd14) ? int'(rounds) : 14;
        need_kx = new_key || !mdl_key_ok || (4'(nr) != mdl_kx_nr);
        push_trace(need_kx, nr, hold, stop_at);
        bus.in_valid   = 1'b1;
        bus.in_new_key = new_key;
        bus.rounds_in  = rounds;
        bus.out_ready  = (hold == 0);
        @(posedge clk_in); #1;
        // Inputs other than in_valid are ignored outside IDLE: scramble them.
        bus.in_valid   = 1'b0;
        bus.in_new_key = 1'($urandom_range(0, 1));
        bus.rounds_in  = 4'($urandom_range(0, 15));
    endtask

    task automatic do_req(input bit new_key, input logic [3:0] rounds, input int hold);
        bit need_kx;
        int nr;
        bit found;
        issue(new_key, rounds, hold, 0, need_kx, nr);
        lat_q.push_back(need_kx ? 2 * nr + 3 : nr + 2);
        if (need_kx) begin
            mdl_key_ok = 1'b1;
            mdl_kx_nr  = 4'(nr);
        end
        found = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus.out_valid) begin
                found = 1;
                break;
            end
            @(posedge clk_in); #1;
        end
        if (!found) begin
            fail_now("out_valid_timeout");
            bus.out_ready = 1'b1;
            return;
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk_in); #1;
            bus.in_valid = (k == 1);   // pulse while the result is still held
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic do_abort_req(input logic [3:0] rounds, input int stop_at);
        bit need_kx;
        int nr;
        bit found;
        issue(1'b0, rounds, 0, stop_at, need_kx, nr);
        found = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_in);
            if (bus.rd_en && bus.rd_idx == 4'(stop_at)) begin
                found = 1;
                break;
            end
        end
        if (!found) fail_now("abort_point_timeout");
        #1 rst_in = 1'b0;
        #1;
        check("abort_outputs", 32'(act_sig()), 32'(mk_sig(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0)));
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        mdl_key_ok = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.in_valid   = 1'b0;
        bus.in_new_key = 1'b0;
        bus.rounds_in  = 4'd0;
        bus.out_ready  = 1'b1;
        rst_in         = 1'b0;
        mdl_key_ok     = 1'b0;
        mdl_kx_nr      = 4'd14;

        repeat (3) @(posedge clk_in);
        #1;
        check("reset_outputs", 32'(act_sig()), 32'(mk_sig(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0)));
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check("idle_after_reset", 32'(act_sig()), 32'(mk_sig(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0)));

        do_req(1'b1, 4'd14, 0);   // new key: KEYX 0..14, latency 31
        do_req(1'b0, 4'd14, 0);   // same key: no KEYX, latency 16
        do_req(1'b0, 4'd10, 0);   // nr change forces KEYX 0..10
        do_req(1'b0, 4'd7,  0);   // illegal -> 14, differs from last expansion
        do_req(1'b0, 4'd14, 5);   // result held 6 cycles, in_valid pulse ignored
        do_abort_req(4'd14, 6);   // reset during RND at rd_idx 6
        do_req(1'b0, 4'd14, 0);   // key invalidated: KEYX despite in_new_key=0
        do_req(1'b0, 4'd12, 0);   // nr 12 expansion
        do_req(1'b0, 4'd12, 0);   // reuse nr 12 key

        repeat (4) @(posedge clk_in);
        #1;
        check("trace_queue_drained", 32'(exp_q.size()), 32'd0);
        check("latency_queue_drained", 32'(lat_q.size()), 32'd0);
        check("final_idle", 32'(act_sig()), 32'(mk_sig(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
